digit_sequencer: RTL and testbench
==================================

Name: digit_sequencer

Overview:
- Upstream stage for the board display path: turns a raw pushbutton and a direction switch into a clean, registered 4-bit digit stream.
- Downstream, the seven-segment display stage renders that digit on HEX0 and mirrors status on LEDR.
- Internally the block synchronizes and debounces the active-low key, detects press events, and steps a wrapping up/down counter.
- It also keeps a 10-bit history of press directions for the LEDs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a key level change; legal range 1..255.
- MAX_COUNT, 9: highest digit value; the counter wraps between 0 and MAX_COUNT; legal range 1..15.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous active-low reset.
- key_n  input  1  raw pushbutton, 0 = pressed; asynchronous and bouncy.
- up_dn  input  1  direction switch, 1 = count up, 0 = count down; sampled on the event cycle.
- enable  input  1  1 = press events update the counter; 0 = events are discarded (history is still not shifted).
- digit  output  4  current digit, 0..MAX_COUNT.
- digit_valid  output  1  one-cycle pulse in the cycle digit takes a new value.
- wrap  output  1  one-cycle pulse, coincident with digit_valid, when the step wrapped (MAX_COUNT->0 or 0->MAX_COUNT).
- led  output  10  press-direction history; bit 0 = newest.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - digit=0, digit_valid=0, wrap=0, led=0.
  - Both synchronizer flops=1 (released); debouncer state RELEASED; debounce counter=0.
  - Reset mid-debounce or mid-press discards all progress.
  - After release, a key still held low must be re-debounced before it is accepted.
- Synchronizer: two flops on key_n; ks is the second flop output.
- Debouncer FSM (states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; 8-bit counter cnt):
  - RELEASED: ks=0 -> PRESS_WAIT with cnt=1.
  - PRESS_WAIT: ks=1 -> RELEASED with cnt=0 (bounce rejected). ks=0 and cnt=DEBOUNCE_CYCLES -> PRESSED and raise press_evt for that cycle. Otherwise cnt+1.
  - PRESSED: ks=1 -> RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: ks=0 -> PRESSED (no new event). ks=1 and cnt=DEBOUNCE_CYCLES -> RELEASED. Otherwise cnt+1.
  - press_evt is a registered single-cycle pulse asserted on the edge that enters PRESSED.
- Counter, on the edge after press_evt=1 and enable=1:
  - up_dn=1: digit = (digit==MAX_COUNT) ? 0 : digit+1; wrap=1 iff digit was MAX_COUNT.
  - up_dn=0: digit = (digit==0) ? MAX_COUNT : digit-1; wrap=1 iff digit was 0.
  - digit_valid=1 for exactly that cycle.
  - led = {led[8:0], up_dn}.
- press_evt=1 with enable=0: no change to digit or led; digit_valid=0 and wrap=0.
- Latency:
  - key_n first sampled 0 at edge E and held stable: press_evt is high after edge E+2+DEBOUNCE_CYCLES.
  - digit, digit_valid and wrap are updated at edge E+3+DEBOUNCE_CYCLES.
- A held key yields exactly one event; no autorepeat.
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples never produce an event.
- Releases shorter than DEBOUNCE_CYCLES samples while PRESSED are absorbed.
- up_dn and enable changing while the key is held have no effect until the next event.
- Width rule: all digit arithmetic is 4-bit unsigned and never exceeds MAX_COUNT.
- Outputs digit, digit_valid, wrap and led are all registered; there are no combinational input-to-output paths.

Decomposition:
- Package digit_seq_pkg holds:
  - DIGIT_W=4 and LED_W=10
  - debounce state enum typedef (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT)
  - CNT_W=8
- Sub-module key_debouncer contains the synchronizer, the FSM and the counter.
  - Ports: Clock, Resetn, key_n, press_evt; parameter DEBOUNCE_CYCLES.
- digit_sequencer instantiates key_debouncer and owns the counter and history logic.

Test Plan:
1. Reset, then hold key_n=0 for 20 cycles with up_dn=1, enable=1, defaults -> single digit_valid pulse exactly 7 edges after the first low sample; digit=1, wrap=0, led=0000000001.
2. Apply 10 clean presses with up_dn=1 starting from digit=0, MAX_COUNT=9 -> digit runs 1..9 then 0; wrap pulses only on the 9->0 step; led=1111111111.
3. From reset, one press with up_dn=0 -> digit=9, wrap=1, led=0000000000; a second down press -> digit=8, wrap=0.
4. Bounce: key_n low for 3 cycles, high for 1, low for 3, then high -> no digit_valid; then key_n low for 10 cycles -> exactly one event.
5. Assert enable=0 and press -> no digit_valid and digit/led unchanged; set enable=1 and press again -> normal update.
6. Drop Resetn during PRESS_WAIT (cnt=2) with the key still held -> all outputs 0 immediately; after Resetn rises, the held key produces an event exactly DEBOUNCE_CYCLES+3 edges after the first sampled low.

Source files
------------

// File: rtl/digit_seq_pkg.sv
// Shared types and widths for the digit sequencer.
// Imported by the debouncer and the sequencer top.
package digit_seq_pkg;

  localparam int DIGIT_W = 4;
  localparam int LED_W   = 10;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low key.
// Emits a one-cycle registered pulse per accepted press.
module key_debouncer
  import digit_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic            s1;
  logic            ks;
  db_state_t       state;
  db_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic            evt_nx;

  // Two-flop synchronizer; idles released (high)
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1 <= 1'b1;
      ks <= 1'b1;
    end else begin
      s1 <= key_n;
      ks <= s1;
    end
  end

  // Debounce state, counter and event pulse registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= RELEASED;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      press_evt <= evt_nx;
    end
  end

  // Next-state: count stable samples before accepting a level change
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    evt_nx   = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!ks) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (ks) begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end else if (cnt == LIMIT) begin
          state_nx = PRESSED;
          evt_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (ks) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!ks) begin
          state_nx = PRESSED;
        end else if (cnt == LIMIT) begin
          state_nx = RELEASED;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = RELEASED;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/digit_sequencer.sv
// Debounced key steps a wrapping up/down digit.
// Keeps a direction history for the LEDs.
module digit_sequencer
  import digit_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COUNT       = 9
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               key_n,
  input  logic               up_dn,
  input  logic               enable,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  output logic               wrap,
  output logic [LED_W-1:0]   led
);

  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MAX_COUNT);

  logic press_evt;
  logic step;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .key_n    (key_n),
    .press_evt(press_evt)
  );

  assign step = press_evt & enable;

  // Step the digit on each enabled event and log its direction
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      wrap        <= 1'b0;
      led         <= '0;
    end else begin
      digit_valid <= step;
      wrap        <= 1'b0;
      if (step) begin
        led <= {led[LED_W-2:0], up_dn};
        if (up_dn) begin
          if (digit == MAXV) begin
            digit <= '0;
            wrap  <= 1'b1;
          end else begin
            digit <= digit + 1'b1;
          end
        end else begin
          if (digit == '0) begin
            digit <= MAXV;
            wrap  <= 1'b1;
          end else begin
            digit <= digit - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed self-checking bench for digit_sequencer.
// Default parameters: DEBOUNCE_CYCLES=4, MAX_COUNT=9.
module tb_digit_sequencer;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic       up_dn;
  logic       enable;
  logic [3:0] digit;
  logic       digit_valid;
  logic       wrap;
  logic [9:0] led;

  int n_chk;
  int n_fail;
  int edge_i;
  int nv;
  int vedge;
  int vdig;
  int vwrap;
  int vled;

  digit_sequencer dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .key_n      (key_n),
    .up_dn      (up_dn),
    .enable     (enable),
    .digit      (digit),
    .digit_valid(digit_valid),
    .wrap       (wrap),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_i++;
    if (digit_valid === 1'b1) begin
      nv++;
      vedge = edge_i;
      vdig  = int'(digit);
      vwrap = int'(wrap);
      vled  = int'(led);
    end
  endtask

  task automatic clr();
    edge_i = 0;
    nv     = 0;
    vedge  = -1;
    vdig   = -1;
    vwrap  = -1;
    vled   = -1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    key_n  = 1'b1;
    up_dn  = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic press(input int hold);
    clr();
    key_n = 1'b0;
    repeat (hold) tick();
    key_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr();
    do_reset();

    // 1: reset state and latency of a held key
    chk("rst_digit", int'(digit), 0);
    chk("rst_valid", int'(digit_valid), 0);
    chk("rst_led", int'(led), 0);
    press(20);
    chk("t1_nv", nv, 1);
    chk("t1_lat", vedge - 1, 7);
    chk("t1_digit", vdig, 1);
    chk("t1_wrap", vwrap, 0);
    chk("t1_led", vled, 1);
    chk("t1_vld_drop", int'(digit_valid), 0);

    // 2: ten up presses, wrap only on 9->0
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      press(10);
      chk($sformatf("t2_nv%0d", i), nv, 1);
      chk($sformatf("t2_dig%0d", i), vdig, i % 10);
      chk($sformatf("t2_wrap%0d", i), vwrap, (i == 10) ? 1 : 0);
    end
    chk("t2_led", int'(led), 10'h3FF);

    // 3: down from 0 wraps to 9, then 8
    do_reset();
    up_dn = 1'b0;
    press(10);
    chk("t3_dig_a", vdig, 9);
    chk("t3_wrap_a", vwrap, 1);
    chk("t3_led_a", vled, 0);
    press(10);
    chk("t3_dig_b", vdig, 8);
    chk("t3_wrap_b", vwrap, 0);

    // 4: short bounces are rejected, then a real press
    clr();
    up_dn = 1'b1;
    key_n = 1'b0;
    repeat (3) tick();
    key_n = 1'b1;
    tick();
    key_n = 1'b0;
    repeat (3) tick();
    key_n = 1'b1;
    repeat (10) tick();
    chk("t4_bounce_nv", nv, 0);
    chk("t4_bounce_dig", int'(digit), 8);
    press(10);
    chk("t4_nv", nv, 1);
    chk("t4_dig", vdig, 9);
    chk("t4_led", vled, 1);

    // 5: disabled press is discarded
    enable = 1'b0;
    press(12);
    chk("t5_off_nv", nv, 0);
    chk("t5_off_dig", int'(digit), 9);
    chk("t5_off_led", int'(led), 1);
    enable = 1'b1;
    press(10);
    chk("t5_on_nv", nv, 1);
    chk("t5_on_dig", vdig, 0);
    chk("t5_on_wrap", vwrap, 1);
    chk("t5_on_led", vled, 3);

    // 6: reset during PRESS_WAIT, held key re-debounced
    press(10);
    chk("t6_pre_dig", int'(digit), 1);
    clr();
    key_n = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dig", int'(digit), 0);
    chk("t6_rst_led", int'(led), 0);
    chk("t6_rst_vld", int'(digit_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    repeat (14) tick();
    chk("t6_nv", nv, 1);
    chk("t6_lat", vedge - 1, 7);
    chk("t6_dig", vdig, 1);
    key_n = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
